// File: rtl/coef_pack64_pkg.sv
// Shared configuration for the coef_pack64 coefficient packer: bus width,
// fill counter width, FSM states and the coefficient-width range check.
package coef_pack64_pkg;

  localparam int unsigned BUS_W  = 64;
  localparam int unsigned FILL_W = 7;
  localparam int unsigned D_MIN  = 1;
  localparam int unsigned D_MAX  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DRAIN
  } state_e;

  function automatic bit d_in_range(input int unsigned d);
    return (d >= D_MIN) && (d <= D_MAX);
  endfunction

endpackage

// File: rtl/coef_pack64_accum.sv
// Accumulator, fill counter and shift/merge logic for coef_pack64.
// PACK_MSB_FIRST_EN selects Frodo.Pack (MSB-first, big-endian) bit order.
module coef_pack64_accum
  import coef_pack64_pkg::*;
#(
  parameter int unsigned D = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [D-1:0]     coef_i,
  input  logic             load_i,
  input  logic             flush_i,
  output logic [BUS_W-1:0] word_o,
  output logic             word_valid_o,
  output logic             pending_o
);

  localparam int unsigned WIDE_W = BUS_W + D_MAX;

  logic [BUS_W-1:0]  acc_q, acc_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [FILL_W-1:0] fill_sum;
  logic              wrap;
  logic [WIDE_W-1:0] merged;
  logic [BUS_W-1:0]  merged_word;
  logic [BUS_W-1:0]  spill;

  assign fill_sum = fill_q + FILL_W'(D);
  assign wrap     = (fill_sum >= FILL_W'(BUS_W));

  // The merge runs D_MAX bits wider than the bus so the part of a
  // coefficient that overflows the current word lands in the spill field.
`ifdef PACK_MSB_FIRST_EN
  assign merged      = {acc_q, {D_MAX{1'b0}}}
                     | ((WIDE_W'(coef_i) << (WIDE_W - D)) >> fill_q);
  assign merged_word = merged[WIDE_W-1:D_MAX];
  assign spill       = {merged[D_MAX-1:0], {(BUS_W-D_MAX){1'b0}}};
`else
  assign merged      = {{D_MAX{1'b0}}, acc_q} | (WIDE_W'(coef_i) << fill_q);
  assign merged_word = merged[BUS_W-1:0];
  assign spill       = {{(BUS_W-D_MAX){1'b0}}, merged[WIDE_W-1:BUS_W]};
`endif

  always_comb begin
    acc_d        = acc_q;
    fill_d       = fill_q;
    word_o       = merged_word;
    word_valid_o = 1'b0;
    if (flush_i) begin
      word_o       = acc_q;
      word_valid_o = 1'b1;
      acc_d        = '0;
      fill_d       = '0;
    end else if (load_i) begin
      if (wrap) begin
        word_valid_o = 1'b1;
        acc_d        = spill;
        fill_d       = fill_sum - FILL_W'(BUS_W);
      end else begin
        acc_d  = merged_word;
        fill_d = fill_sum;
      end
    end
  end

  assign pending_o = (fill_d != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/coef_pack64.sv
// Packs a stream of D-bit coefficients into zero-padded 64-bit words.
// Bit order follows PACK_MSB_FIRST_EN (default LSB-first), set in the accumulator.
module coef_pack64
  import coef_pack64_pkg::*;
#(
  parameter int unsigned D  = 16,
  parameter int unsigned CW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_start,
  input  logic [CW-1:0]    cmd_numCoefs,
  output logic             cmd_canReceive,
  input  logic [D-1:0]     in,
  input  logic             in_isReady,
  output logic             in_canReceive,
  output logic             in_isLast,
  output logic [BUS_W-1:0] out,
  output logic             out_isReady,
  input  logic             out_canReceive,
  output logic             out_isLast
);

  if (!d_in_range(D)) begin : g_bad_d
    $error("coef_pack64: D must be in 1..16");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    remaining_q, remaining_d;
  logic [BUS_W-1:0] out_q, out_d;
  logic             out_full_q, out_full_d;
  logic             out_last_q, out_last_d;

  logic             out_xfer;
  logic             accept;
  logic             last_accept;
  logic             flush;
  logic [BUS_W-1:0] word;
  logic             word_valid;
  logic             pending;

  assign out_xfer       = out_full_q & out_canReceive;
  assign in_canReceive  = (state_q == ST_RUN) & (remaining_q != '0)
                        & (~out_full_q | out_canReceive);
  assign accept         = in_isReady & in_canReceive;
  assign last_accept    = accept & (remaining_q == CW'(1));
  assign in_isLast      = in_canReceive & (remaining_q == CW'(1));
  assign flush          = (state_q == ST_FLUSH) & (~out_full_q | out_canReceive);
  assign cmd_canReceive = (state_q == ST_IDLE);

  assign out         = out_q;
  assign out_isReady = out_xfer;
  assign out_isLast  = out_xfer & out_last_q;

  coef_pack64_accum #(
    .D(D)
  ) u_accum (
    .clk_i       (clk),
    .rst_ni      (rst),
    .coef_i      (in),
    .load_i      (accept),
    .flush_i     (flush),
    .word_o      (word),
    .word_valid_o(word_valid),
    .pending_o   (pending)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_start && (cmd_numCoefs != '0)) begin
          state_d     = ST_RUN;
          remaining_d = cmd_numCoefs;
        end
      end
      ST_RUN: begin
        if (accept) begin
          remaining_d = remaining_q - CW'(1);
        end
        if (last_accept) begin
          state_d = pending ? ST_FLUSH : ST_DRAIN;
        end
      end
      ST_FLUSH: begin
        if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_xfer) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A reload in the same cycle as a transfer keeps the register full.
  always_comb begin
    out_d      = out_q;
    out_full_d = out_full_q;
    out_last_d = out_last_q;
    if (word_valid) begin
      out_d      = word;
      out_full_d = 1'b1;
      out_last_d = flush | (last_accept & ~pending);
    end else if (out_xfer) begin
      out_full_d = 1'b0;
      out_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      out_q       <= '0;
      out_full_q  <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      out_q       <= out_d;
      out_full_q  <= out_full_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_coef_pack64.sv
// Bench for coef_pack64: D=16 and D=15 instances against a bit-stream model.
module tb_coef_pack64;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_start;
  logic [15:0] cmd_num;
  logic [15:0] in_data;
  logic        in_rdy;
  logic        out_cr;
  int          sel;

  logic        a_cmd_cr, a_in_cr, a_in_last, a_out_rdy, a_out_last;
  logic [63:0] a_out;
  logic        b_cmd_cr, b_in_cr, b_in_last, b_out_rdy, b_out_last;
  logic [63:0] b_out;

  logic        m_cmd_cr, m_in_cr, m_in_last, m_out_rdy, m_out_last;
  logic [63:0] m_out;

  int errors = 0;
  int checks = 0;

  logic [15:0] coefs[$];
  logic [63:0] exp_words[$];
  logic [63:0] got_words[$];

  always #5 clk = ~clk;

  coef_pack64 #(.D(16), .CW(16)) u_d16 (
    .clk           (clk),
    .rst           (rst),
    .cmd_start     (cmd_start & (sel == 0)),
    .cmd_numCoefs  (cmd_num),
    .cmd_canReceive(a_cmd_cr),
    .in            (in_data),
    .in_isReady    (in_rdy & (sel == 0)),
    .in_canReceive (a_in_cr),
    .in_isLast     (a_in_last),
    .out           (a_out),
    .out_isReady   (a_out_rdy),
    .out_canReceive(out_cr),
    .out_isLast    (a_out_last)
  );

  coef_pack64 #(.D(15), .CW(16)) u_d15 (
    .clk           (clk),
    .rst           (rst),
    .cmd_start     (cmd_start & (sel == 1)),
    .cmd_numCoefs  (cmd_num),
    .cmd_canReceive(b_cmd_cr),
    .in            (in_data[14:0]),
    .in_isReady    (in_rdy & (sel == 1)),
    .in_canReceive (b_in_cr),
    .in_isLast     (b_in_last),
    .out           (b_out),
    .out_isReady   (b_out_rdy),
    .out_canReceive(out_cr),
    .out_isLast    (b_out_last)
  );

  assign m_cmd_cr   = (sel == 0) ? a_cmd_cr   : b_cmd_cr;
  assign m_in_cr    = (sel == 0) ? a_in_cr    : b_in_cr;
  assign m_in_last  = (sel == 0) ? a_in_last  : b_in_last;
  assign m_out_rdy  = (sel == 0) ? a_out_rdy  : b_out_rdy;
  assign m_out_last = (sel == 0) ? a_out_last : b_out_last;
  assign m_out      = (sel == 0) ? a_out      : b_out;

  // Reference: concatenate coefficient bits into one stream, cut into 64-bit words.
  task automatic build_expected(input int d);
    int n;
    int nw;
    int pos;
    int wi;
    int bi;
    logic [15:0] c;
    logic [63:0] w;
    n  = coefs.size();
    nw = (n * d + 63) / 64;
    exp_words.delete();
    for (int i = 0; i < nw; i++) exp_words.push_back(64'h0);
    for (int k = 0; k < n; k++) begin
      c = coefs[k];
      for (int b = 0; b < d; b++) begin
`ifdef PACK_MSB_FIRST_EN
        pos = k * d + (d - 1 - b);
        wi  = pos / 64;
        bi  = 63 - (pos % 64);
`else
        pos = k * d + b;
        wi  = pos / 64;
        bi  = pos % 64;
`endif
        w     = exp_words[wi];
        w[bi] = c[b];
        exp_words[wi] = w;
      end
    end
  endtask

  task automatic fill_random(input int n, input int d);
    logic [15:0] v;
    coefs.delete();
    for (int i = 0; i < n; i++) begin
      v = 16'($urandom);
      if (d == 15) v[15] = 1'b0;
      coefs.push_back(v);
    end
  endtask

  // ocr_mode: 0 always ready, 1 stalled for 10 cycles, 2 random.
  task automatic run_job(input string name, input int ocr_mode, input int rdy_mode,
                         input bit poke_busy, output int first_acc, output int last_acc,
                         output int acc_at10);
    int idx;
    int widx;
    int cyc;
    int n;
    int nw;
    idx = 0; widx = 0; cyc = 0;
    n = coefs.size();
    build_expected((sel == 0) ? 16 : 15);
    nw = exp_words.size();
    got_words.delete();
    first_acc = -1; last_acc = -1; acc_at10 = -1;
    @(posedge clk); #1;
    cmd_num   = 16'(n);
    cmd_start = 1'b1;
    in_rdy    = 1'b0;
    out_cr    = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    while (widx < nw && cyc < 2000) begin
      case (ocr_mode)
        0:       out_cr = 1'b1;
        1:       out_cr = (cyc >= 10);
        default: out_cr = 1'($urandom_range(0, 1));
      endcase
      in_rdy  = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      in_data = (idx < n) ? coefs[idx] : 16'($urandom);
      if (poke_busy && cyc == 2) begin
        cmd_start = 1'b1;
        cmd_num   = 16'd5;
      end else begin
        cmd_start = 1'b0;
      end
      if (cyc == 10) acc_at10 = idx;
      #4;
      checks++;
      if (m_cmd_cr !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_cmd_canReceive cyc=%0d got=%b want=0", name, cyc, m_cmd_cr);
      end
      if (m_in_cr && in_rdy) begin
        checks++;
        if (idx >= n) begin
          errors++;
          $display("FAIL %s over_accept idx=%0d got=accepted want=none", name, idx);
        end else if (m_in_last !== (idx == n - 1)) begin
          errors++;
          $display("FAIL %s in_isLast idx=%0d got=%b want=%b", name, idx, m_in_last, (idx == n - 1));
        end
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        idx++;
      end
      if (m_out_rdy) begin
        checks++;
        got_words.push_back(m_out);
        if (m_out !== exp_words[widx] || m_out_last !== (widx == nw - 1)) begin
          errors++;
          $display("FAIL %s word%0d got=%h last=%b want=%h last=%b", name, widx,
                   m_out, m_out_last, exp_words[widx], (widx == nw - 1));
        end
        widx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_rdy    = 1'b0;
    cmd_start = 1'b0;
    checks++;
    if (widx != nw) begin
      errors++;
      $display("FAIL %s word_count_or_timeout got=%0d want=%0d", name, widx, nw);
    end
    checks++;
    if (idx != n) begin
      errors++;
      $display("FAIL %s accept_count got=%0d want=%0d", name, idx, n);
    end
    for (int i = 0; i < 3; i++) begin
      #4;
      checks++;
      if (m_cmd_cr !== 1'b1 || m_out_rdy !== 1'b0 || m_in_cr !== 1'b0) begin
        errors++;
        $display("FAIL %s post_idle cyc=%0d got cmd_cr=%b out_rdy=%b in_cr=%b want 1/0/0",
                 name, i, m_cmd_cr, m_out_rdy, m_in_cr);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (a_cmd_cr !== 1'b1 || a_in_cr !== 1'b0 || a_in_last !== 1'b0 || a_out !== 64'h0 ||
        a_out_rdy !== 1'b0 || a_out_last !== 1'b0 || b_cmd_cr !== 1'b1 || b_out !== 64'h0 ||
        b_out_rdy !== 1'b0 || b_in_cr !== 1'b0) begin
      errors++;
      $display("FAIL %s got cmd_cr=%b/%b in_cr=%b out=%h/%h out_rdy=%b want 1/1 0 0/0 0",
               name, a_cmd_cr, b_cmd_cr, a_in_cr, a_out, b_out, a_out_rdy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset_asserted");
    rst = 1'b1;
    @(posedge clk); #4;
    check_idle_outputs("reset_released");
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int f, l, a;
    sel = 0;
    coefs = '{16'd1, 16'd2, 16'd3, 16'd4};
    run_job("basic_d16", 0, 0, 1'b0, f, l, a);
    checks++;
`ifdef PACK_MSB_FIRST_EN
    if (got_words.size() != 1 || got_words[0] !== 64'h0001_0002_0003_0004) begin
`else
    if (got_words.size() != 1 || got_words[0] !== 64'h0004_0003_0002_0001) begin
`endif
      errors++;
      $display("FAIL basic_const got_n=%0d got=%h", got_words.size(),
               (got_words.size() > 0) ? got_words[0] : 64'h0);
    end
  endtask

  task automatic test_d15();
    int f, l, a;
    sel = 1;
    coefs = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    run_job("d15_flush", 0, 0, 1'b0, f, l, a);
    checks++;
`ifdef PACK_MSB_FIRST_EN
    if (got_words.size() != 2 || got_words[0] !== '1 || got_words[1] !== 64'hFFE0_0000_0000_0000) begin
`else
    if (got_words.size() != 2 || got_words[0] !== '1 || got_words[1] !== 64'h0000_0000_0000_07FF) begin
`endif
      errors++;
      $display("FAIL d15_const got_n=%0d want 2 words all-ones then 11-bit residue",
               got_words.size());
    end
    sel = 0;
  endtask

  task automatic test_backpressure();
    int f, l, a;
    sel = 0;
    fill_random(8, 16);
    run_job("backpressure", 1, 0, 1'b0, f, l, a);
    checks++;
    if (a !== 4) begin
      errors++;
      $display("FAIL backpressure_stall accepts_before_release got=%0d want=4", a);
    end
  endtask

  task automatic test_back_to_back();
    int f, l, a;
    sel = 0;
    fill_random(8, 16);
    run_job("no_bubble", 0, 0, 1'b0, f, l, a);
    checks++;
    if (f !== 0 || l !== 7) begin
      errors++;
      $display("FAIL no_bubble accept_window got=%0d..%0d want=0..7", f, l);
    end
  endtask

  task automatic test_reset_midjob();
    int f, l, a;
    sel = 0;
    @(posedge clk); #1;
    out_cr    = 1'b1;
    cmd_num   = 16'd4;
    cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    in_rdy    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 16'hA5A0 + 16'(i);
      @(posedge clk); #1;
    end
    in_rdy = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_idle_outputs("reset_midjob");
    @(posedge clk); #1;
    rst = 1'b1;
    fill_random(4, 16);
    run_job("after_reset", 0, 0, 1'b0, f, l, a);
  endtask

  task automatic test_ignored_starts();
    int f, l, a;
    sel = 0;
    @(posedge clk); #1;
    cmd_num   = 16'd0;
    cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #4;
      checks++;
      if (m_cmd_cr !== 1'b1 || m_in_cr !== 1'b0 || m_out_rdy !== 1'b0) begin
        errors++;
        $display("FAIL zero_len_start cyc=%0d got cmd_cr=%b in_cr=%b out_rdy=%b want 1/0/0",
                 i, m_cmd_cr, m_in_cr, m_out_rdy);
      end
      @(posedge clk); #1;
    end
    fill_random(6, 16);
    run_job("busy_start", 0, 0, 1'b1, f, l, a);
  endtask

  task automatic test_random();
    int f, l, a;
    for (int j = 0; j < 8; j++) begin
      sel = j % 2;
      fill_random($urandom_range(1, 20), (sel == 0) ? 16 : 15);
      run_job((sel == 0) ? "random_d16" : "random_d15", 2, 1, 1'($urandom_range(0, 1)), f, l, a);
    end
    sel = 0;
  endtask

  initial begin
    rst       = 1'b0;
    cmd_start = 1'b0;
    cmd_num   = '0;
    in_data   = '0;
    in_rdy    = 1'b0;
    out_cr    = 1'b0;
    sel       = 0;
    test_reset();
    test_basic();
    test_d15();
    test_backpressure();
    test_back_to_back();
    test_reset_midjob();
    test_ignored_starts();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coef_pack64.md
Name: coef_pack64

Overview:
- Packs a stream of D-bit matrix coefficients into dense 64-bit bus words and zero-pads the final word.
- Sits directly upstream of the 64-bit deserialiser input, so packed matrices (B, C1, C2) can be written into wide buffers.
- Input and output use the team's standard isReady/canReceive bus: a transfer happens only in a cycle where isReady and canReceive are both high.

Parameters:
D, 16, coefficient width in bits; legal range 1..16 (FrodoKEM uses 15/16 for B, C1, C2).
CW, 16, width of the coefficient-count field.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-low (0 = reset).
cmd_start  input  1  start a packing job; taken only while cmd_canReceive=1.
cmd_numCoefs  input  CW  number of coefficients in the job; sampled on an accepted start.
cmd_canReceive  output  1  block idle: no coefficients pending, no residual bits, output register empty.
in  input  D  coefficient value.
in_isReady  input  1  coefficient transfer; legal only when in_canReceive=1.
in_canReceive  output  1  block will accept a coefficient this cycle.
in_isLast  output  1  the coefficient accepted this cycle is the job's last.
out  output  64  packed word.
out_isReady  output  1  word transferred this cycle.
out_canReceive  input  1  downstream can take a word.
out_isLast  output  1  the word transferred this cycle is the job's last.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; remaining count, fill, accumulator and output register cleared.
- Output values during and right after reset: cmd_canReceive=1; all other outputs 0.
- States:
  - IDLE: exits to RUN on cmd_start with numCoefs>0. A start with numCoefs=0 is a no-op and the block stays in IDLE.
  - RUN: exits to FLUSH once the last coefficient is accepted and fill>0. If fill=0 at that point, it goes straight to DRAIN.
  - FLUSH: moves the padded residual word into the output register once that register is free, then goes to DRAIN.
  - DRAIN: returns to IDLE when the output register has been transferred.
- Packing, LSB-first:
  - Coefficient k is placed at bit position fill of the current word; fill is 7 bits, range 0..63.
  - If fill+D<64: accumulator |= in<<fill, fill += D.
  - Otherwise the completed word is (acc | in<<fill)[63:0] and is loaded into the output register. Then acc = in>>(64-fill) and fill = fill+D-64.
  - The accumulator is 64 bits. Residual bits above the new fill are always zero.
- Output register is one word deep; outFull is its flag.
  - out_isReady = outFull & out_canReceive. The register clears on transfer unless it is reloaded in the same cycle.
- in_canReceive = (state==RUN) & remaining!=0 & (~outFull | out_canReceive).
  - A word can therefore be drained and refilled in the same cycle, giving full throughput: one coefficient per cycle.
  - The combinational path out_canReceive -> in_canReceive is intentional.
- in_isLast = in_canReceive & remaining==1.
- Total words per job = ceil(numCoefs*D/64). The last word's unused high bits are 0.
- out_isLast is asserted with the transfer of the final word, whether it was full or flushed.
- Latency: a completed word is visible on out in the cycle after the coefficient that completed it is accepted.
- A cmd_start while cmd_canReceive=0 is ignored, with no effect on the running job.
- rst asserted mid-job discards all pending data. The next job after reset starts with fill=0.

Optional Feature:
- PACK_MSB_FIRST_EN defined: FrodoKEM Frodo.Pack bit order.
  - Each coefficient's MSB is emitted first.
  - The word's first bit is bit 63. Bytes are big-endian, i.e. the byte stream is out[63:56], out[55:48], ...
  - Padding goes in the low bits of the final word.
- PACK_MSB_FIRST_EN undefined: LSB-first order as described above; padding goes in the high bits.

Decomposition:
- Shared config include holds BUS_W=64, the state encoding constants (IDLE, RUN, FLUSH, DRAIN) and the D range check macro.
- One sub-module, pack_accum: accumulator + fill counter + shift/merge logic.
  - Inputs: coefficient, load, flush.
  - Outputs: word, wordValid.
  - The bit-order option lives only in pack_accum.
- The top level owns the FSM, the remaining counter and the output register.

Test Plan:
- D=16, numCoefs=4, in=1,2,3,4, out_canReceive=1 -> one word 0x0004_0003_0002_0001 with out_isLast=1; cmd_canReceive=1 one cycle later.
- D=15, numCoefs=5, in=0x7FFF each -> 2 words: word0=0xFFFF_FFFF_FFFF_FFFF, word1=0x0000_0000_0000_07FF with out_isLast; in_isLast on the 5th input.
- D=16, numCoefs=8, out_canReceive=0 until cycle 10 -> in_canReceive drops after 4 accepts plus outFull; no data lost; 2 words in order.
- Same job with out_canReceive=1 continuously -> 8 accepts in 8 consecutive cycles (no bubble).
- rst=0 asserted mid-job after 3 coefficients -> all outputs 0, cmd_canReceive=1; a new job of 4 produces a word containing only the new data.
- cmd_start while busy, and cmd_start with numCoefs=0 -> both ignored; the running job is unaffected and no words are emitted for the 0-length start.
